// File: rtl/dragonfang_pkg.sv
// Core-wide types and sizing constants for the dragonfang pipeline.
package dragonfang_pkg;

  import riscv_v_pkg::*;

  localparam int unsigned TAG_LENGTH                   = 5;
  localparam int unsigned NUMBER_WRITE_BACK_REQUESTERS = 3;

  typedef struct packed {
    logic [TAG_LENGTH-1:0] tag;
    logic [VLEN-1:0]       data;
  } data_packet_t;

endpackage

// File: rtl/riscv_v_pkg.sv
// Vector extension architectural constants shared across the vector pipeline.
package riscv_v_pkg;

  localparam int unsigned VLEN = 128;

endpackage

// File: rtl/vector_write_back_arbiter_pkg.sv
// Local types for the vector write-back arbiter: output register state and pointer sizing.
package vector_write_back_arbiter_pkg;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_write_back_arbiter_if.sv
// Requester/write-port bundle for the vector write-back arbiter.
// master: execution units + register read stage side; slave: the arbiter.
interface vector_write_back_arbiter_if
  import dragonfang_pkg::*;
#(
  parameter int unsigned NUMBER_REQUESTERS = NUMBER_WRITE_BACK_REQUESTERS
);

  logic [NUMBER_REQUESTERS-1:0] request_valid;
  data_packet_t                 request_packet [NUMBER_REQUESTERS];
  logic [NUMBER_REQUESTERS-1:0] request_ready;
  logic                         write_back_stall;
  logic                         flush;
  logic                         write_back_request;
  data_packet_t                 write_back_packet;

  modport master (
    output request_valid,
    output request_packet,
    output write_back_stall,
    output flush,
    input  request_ready,
    input  write_back_request,
    input  write_back_packet
  );

  modport slave (
    input  request_valid,
    input  request_packet,
    input  write_back_stall,
    input  flush,
    output request_ready,
    output write_back_request,
    output write_back_packet
  );

endinterface

// File: rtl/vector_write_back_arbiter_arbiter.sv
// Combinational one-hot grant. VECTOR_WRITE_BACK_ROUND_ROBIN_EN: search upward from pointer
// with wrap-around; otherwise fixed priority (lowest index) and pointer is ignored.
module vector_round_robin_arbiter #(
  parameter int unsigned NUMBER_REQUESTERS = 3,
  parameter int unsigned POINTER_WIDTH     = 2
) (
  input  logic [NUMBER_REQUESTERS-1:0] request,
  input  logic [POINTER_WIDTH-1:0]     pointer,
  output logic [NUMBER_REQUESTERS-1:0] grant
);

  logic found;

`ifdef VECTOR_WRITE_BACK_ROUND_ROBIN_EN
  int unsigned idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < NUMBER_REQUESTERS; off++) begin
      idx = (32'(pointer) + off) % NUMBER_REQUESTERS;
      if (!found && request[idx[POINTER_WIDTH-1:0]]) begin
        grant[idx[POINTER_WIDTH-1:0]] = 1'b1;
        found                         = 1'b1;
      end
    end
  end
`else
  logic unused_pointer;
  assign unused_pointer = ^pointer;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUMBER_REQUESTERS; i++) begin
      if (!found && request[i[POINTER_WIDTH-1:0]]) begin
        grant[i[POINTER_WIDTH-1:0]] = 1'b1;
        found                       = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/vector_write_back_arbiter.sv
// Shares the vector register file write port among execution units through a one-entry
// output register. Arbitration mode selected by VECTOR_WRITE_BACK_ROUND_ROBIN_EN.
module vector_write_back_arbiter
  import dragonfang_pkg::*;
  import vector_write_back_arbiter_pkg::*;
#(
  parameter int unsigned NUMBER_REQUESTERS = NUMBER_WRITE_BACK_REQUESTERS
) (
  input logic                       clock,
  input logic                       reset_n,
  vector_write_back_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = ptr_width(NUMBER_REQUESTERS);

  wb_state_e                    state, state_next;
  logic                         can_accept;
  logic                         transfer;
  logic [NUMBER_REQUESTERS-1:0] grant;
  logic [PTR_W-1:0]             pointer;
  data_packet_t                 selected;
  data_packet_t                 packet_q;

  vector_round_robin_arbiter #(
    .NUMBER_REQUESTERS (NUMBER_REQUESTERS),
    .POINTER_WIDTH     (PTR_W)
  ) u_arbiter (
    .request (bus.request_valid),
    .pointer (pointer),
    .grant   (grant)
  );

  // A full register may drain and refill in the same cycle unless stalled; flush blocks all grants.
  assign can_accept        = !bus.flush && ((state == WB_EMPTY) || !bus.write_back_stall);
  assign bus.request_ready = can_accept ? grant : '0;
  assign transfer          = |bus.request_ready;

  always_comb begin
    selected = '0;
    for (int unsigned i = 0; i < NUMBER_REQUESTERS; i++) begin
      if (grant[i]) selected = bus.request_packet[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= WB_EMPTY;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = WB_EMPTY;
    end else begin
      unique case (state)
        WB_EMPTY: if (transfer) state_next = WB_FULL;
        WB_FULL:  if (!bus.write_back_stall && !transfer) state_next = WB_EMPTY;
        default:  state_next = WB_EMPTY;
      endcase
    end
  end

  always_comb begin
    bus.write_back_request = (state == WB_FULL);
    bus.write_back_packet  = packet_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      packet_q <= '0;
    else if (transfer) packet_q <= selected;
  end

`ifdef VECTOR_WRITE_BACK_ROUND_ROBIN_EN
  logic [PTR_W-1:0] winner;

  always_comb begin
    winner = '0;
    for (int unsigned i = 0; i < NUMBER_REQUESTERS; i++) begin
      if (grant[i]) winner = PTR_W'(i);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pointer <= '0;
    end else if (transfer) begin
      pointer <= (winner == PTR_W'(NUMBER_REQUESTERS - 1)) ? '0 : winner + 1'b1;
    end
  end
`else
  assign pointer = '0;
`endif

endmodule

// File: tb/tb_vector_write_back_arbiter.sv
// Scoreboard bench for vector_write_back_arbiter: directed scenarios plus random traffic
// checked against a queue-based reference of the write-port behaviour.
module tb_vector_write_back_arbiter;
  import dragonfang_pkg::*;
  import riscv_v_pkg::*;

  localparam int N = 3;

  typedef struct {
    logic         req;
    data_packet_t pkt;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  vector_write_back_arbiter_if #(.NUMBER_REQUESTERS(N)) bus ();

  vector_write_back_arbiter #(.NUMBER_REQUESTERS(N)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int           checks = 0;
  int           errors = 0;
  bit           mon_en = 1'b0;
  exp_t         sb_q [$];
  bit           pend [N];
  data_packet_t pkt  [N];
  bit           m_full = 1'b0;
  data_packet_t m_pkt = '0;
  int           m_ptr = 0;
  int           dut_grant;
  int           seq [6];

  function automatic data_packet_t rand_pkt();
    data_packet_t p;
    p.tag  = TAG_LENGTH'($urandom);
    p.data = '0;
    repeat (VLEN / 32 + 1) p.data = (p.data << 32) | VLEN'($urandom);
    return p;
  endfunction

  // Reference pick: first valid source at or after the search start, wrapping around.
  function automatic int pick(input int start);
    for (int k = 0; k < N; k++) begin
      if (pend[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic int encode(input logic [N-1:0] r);
    int hits = 0;
    int idx  = -1;
    for (int i = 0; i < N; i++) if (r[i]) begin hits++; idx = i; end
    return (hits == 1) ? idx : ((hits == 0) ? -1 : -2);
  endfunction

  task automatic drive_inputs(input logic st, input logic fl);
    for (int i = 0; i < N; i++) begin
      bus.request_valid[i]  = pend[i];
      bus.request_packet[i] = pkt[i];
    end
    bus.write_back_stall = st;
    bus.flush            = fl;
  endtask

  task automatic step(input logic st, input logic fl, input bit rnd);
    bit            acc;
    int            w;
    logic [N-1:0]  exp_ready;
    exp_t          e;
    @(negedge clock);
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pkt[i]  = rand_pkt();
        end
      end
    end
    drive_inputs(st, fl);
    #1;
    acc = !fl && (!m_full || !st);
`ifdef VECTOR_WRITE_BACK_ROUND_ROBIN_EN
    w = acc ? pick(m_ptr) : -1;
`else
    w = acc ? pick(0) : -1;
`endif
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    dut_grant = encode(bus.request_ready);
    checks++;
    if (bus.request_ready !== exp_ready) begin
      errors++;
      $display("FAIL ready t=%0t: got %b want %b", $time, bus.request_ready, exp_ready);
    end
    if (fl) begin
      m_full = 1'b0;
    end else if (w >= 0) begin
      m_full = 1'b1;
      m_pkt  = pkt[w];
      m_ptr  = (w + 1) % N;
      pend[w] = 1'b0;
    end else if (m_full && !st) begin
      m_full = 1'b0;
    end
    e.req = m_full;
    e.pkt = m_pkt;
    sb_q.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic reset_pulse();
    exp_t e;
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.write_back_request !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: write_back_request got %b want 0", bus.write_back_request);
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_inputs(1'b0, 1'b0);
    m_full = 1'b0;
    m_pkt  = '0;
    m_ptr  = 0;
    e.req  = 1'b0;
    e.pkt  = '0;
    sb_q.push_back(e);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: one expected write-port value per cycle, compared just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (mon_en) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow t=%0t: got empty queue want entry", $time);
        end else begin
          e = sb_q.pop_front();
          checks++;
          if (bus.write_back_request !== e.req) begin
            errors++;
            $display("FAIL wb_request t=%0t: got %b want %b", $time, bus.write_back_request, e.req);
          end
          if (e.req) begin
            checks++;
            if (bus.write_back_packet !== e.pkt) begin
              errors++;
              $display("FAIL wb_packet t=%0t: got tag %0d data %h want tag %0d data %h", $time,
                       bus.write_back_packet.tag, bus.write_back_packet.data, e.pkt.tag, e.pkt.data);
            end
          end
        end
      end
    end
  end

  initial begin
    int exp_seq;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pkt[i]  = '0;
    end
    drive_inputs(1'b0, 1'b0);
    repeat (2) @(negedge clock);
    checks++;
    if (bus.write_back_request !== 1'b0 || bus.write_back_packet !== '0 || bus.request_ready !== '0) begin
      errors++;
      $display("FAIL reset_state: got req %b pkt %h ready %b want 0 0 0",
               bus.write_back_request, bus.write_back_packet, bus.request_ready);
    end
    reset_n = 1'b1;

    // All sources continuously valid, no stall.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) begin pend[i] = 1'b1; pkt[i] = rand_pkt(); end
      step(1'b0, 1'b0, 1'b0);
      seq[c] = dut_grant;
    end
    for (int c = 0; c < 6; c++) begin
`ifdef VECTOR_WRITE_BACK_ROUND_ROBIN_EN
      exp_seq = c % 3;
`else
      exp_seq = 0;
`endif
      checks++;
      if (seq[c] != exp_seq) begin
        errors++;
        $display("FAIL grant_seq[%0d]: got %0d want %0d", c, seq[c], exp_seq);
      end
    end
    repeat (4) step(1'b0, 1'b0, 1'b0);

    // Single source 1, tag 5 data 0xA5.
    pend[1] = 1'b1; pkt[1].tag = 5'd5; pkt[1].data = VLEN'(8'hA5);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_grant != 1) begin
      errors++;
      $display("FAIL single_src_grant: got %0d want 1", dut_grant);
    end
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Hold tag 7 under 3 stall cycles while source 2 waits.
    pend[0] = 1'b1; pkt[0].tag = 5'd7; pkt[0].data = rand_pkt().data;
    step(1'b0, 1'b0, 1'b0);
    pend[2] = 1'b1; pkt[2] = rand_pkt();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_grant != 2) begin
      errors++;
      $display("FAIL stall_release_grant: got %0d want 2", dut_grant);
    end
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Same tag from sources 0 and 2 with the pointer at 2.
    pend[1] = 1'b1; pkt[1] = rand_pkt();
    step(1'b0, 1'b0, 1'b0);
    pend[0] = 1'b1; pkt[0].tag = 5'd9; pkt[0].data = VLEN'(8'h11);
    pend[2] = 1'b1; pkt[2].tag = 5'd9; pkt[2].data = VLEN'(8'h22);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Flush while full with source 0 waiting.
    pend[1] = 1'b1; pkt[1] = rand_pkt();
    step(1'b0, 1'b0, 1'b0);
    pend[0] = 1'b1; pkt[0] = rand_pkt();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_grant != 0) begin
      errors++;
      $display("FAIL post_flush_grant: got %0d want 0", dut_grant);
    end

    // Asynchronous reset while full.
    pend[2] = 1'b1; pkt[2] = rand_pkt();
    step(1'b0, 1'b0, 1'b0);
    reset_pulse();

    // Random traffic.
    for (int c = 0; c < 500; c++) begin
      if (c == 250) reset_pulse();
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), 1'b1);
    end
    repeat (4) step(1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
